// File: rtl/sha2_host_ctrl.sv
// sha2_host_ctrl: host-bus register front end that drives the SHA2 coprocessor wrapper.
// Optional start-to-done watchdog is compiled in when SHA2_HOST_TIMEOUT_EN is defined.
module sha2_host_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic [4:0]   bus_addr,
   input  logic [31:0]  bus_wdata,
   input  logic         bus_we,
   input  logic         bus_re,
   output logic [31:0]  bus_rdata,
   output logic         bus_rvalid,
   output logic         irq_done,
   output logic [447:0] plaintext,
   output logic [63:0]  messageSize,
   output logic [2:0]   sha2CSR,
   input  logic [255:0] digest,
   input  logic [2:0]   sha2CSR_o,
   input  logic         regwrite,
   input  logic         csrUpdate
);

   typedef enum logic [2:0] {
      IDLE,
      KICK,
      WAIT_BUSY,
      WAIT_DIGEST,
      WAIT_DONE
   } state_t;

   localparam logic [4:0] A_MSG_LAST = 5'h0D;
   localparam logic [4:0] A_SIZE_LO  = 5'h0E;
   localparam logic [4:0] A_SIZE_HI  = 5'h0F;
   localparam logic [4:0] A_CTRL     = 5'h10;
   localparam logic [4:0] A_STATUS   = 5'h11;
   localparam logic [63:0] MAX_BITS  = 64'd447;

   state_t            state_q, state_d;
   logic [13:0][31:0] msg_q, msg_d;
   logic [63:0]       size_q, size_d;
   logic [7:0][31:0]  dig_q, dig_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              tout_q, tout_d;
   logic              seen_q, seen_d;
   logic              irq_q, irq_d;
   logic              rvalid_q, rvalid_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              idle_wr;
   logic              csr_busy;
   logic              csr_done;

   // Host writes only land while idle, which also keeps plaintext/size frozen during a hash.
   assign idle_wr  = bus_we && (state_q == IDLE);
   assign csr_busy = csrUpdate && (sha2CSR_o == 3'd2);
   assign csr_done = csrUpdate && (sha2CSR_o == 3'd1);

`ifdef SHA2_HOST_TIMEOUT_EN
   logic [31:0] cnt_q, cnt_d;
`else
   logic [31:0] unused_timeout;
   assign unused_timeout = TIMEOUT_CYCLES;
`endif

   always_comb begin
      state_d  = state_q;
      msg_d    = msg_q;
      size_d   = size_q;
      dig_d    = dig_q;
      busy_d   = busy_q;
      done_d   = done_q;
      err_d    = err_q;
      tout_d   = tout_q;
      seen_d   = seen_q;
      irq_d    = 1'b0;
      rvalid_d = bus_re;
      rdata_d  = '0;

      // Read mux looks at current register values, so a same-cycle write is not visible yet.
      if (bus_re) begin
         if (bus_addr <= A_MSG_LAST) begin
            rdata_d = msg_q[4'd13 - bus_addr[3:0]];
         end else if (bus_addr == A_SIZE_LO) begin
            rdata_d = size_q[31:0];
         end else if (bus_addr == A_SIZE_HI) begin
            rdata_d = size_q[63:32];
         end else if (bus_addr == A_STATUS) begin
            rdata_d = {28'd0, tout_q, err_q, done_q, busy_q};
         end else if (bus_addr[4:3] == 2'b11) begin
            rdata_d = dig_q[3'd7 - bus_addr[2:0]];
         end
      end

      if (idle_wr) begin
         if (bus_addr <= A_MSG_LAST) begin
            msg_d[4'd13 - bus_addr[3:0]] = bus_wdata;
         end else if (bus_addr == A_SIZE_LO) begin
            size_d[31:0] = bus_wdata;
         end else if (bus_addr == A_SIZE_HI) begin
            size_d[63:32] = bus_wdata;
         end else if (bus_addr == A_CTRL) begin
            if (bus_wdata[1]) begin
               done_d = 1'b0;
               err_d  = 1'b0;
               tout_d = 1'b0;
            end
            if (bus_wdata[0]) begin
               if (size_q > MAX_BITS) begin
                  err_d = 1'b1;
                  irq_d = 1'b1;
               end else begin
                  done_d  = 1'b0;
                  err_d   = 1'b0;
                  tout_d  = 1'b0;
                  busy_d  = 1'b1;
                  seen_d  = 1'b0;
                  state_d = KICK;
               end
            end
         end
      end

      unique case (state_q)
         KICK: state_d = WAIT_BUSY;
         WAIT_BUSY: begin
            // A done update before busy means the wrapper finished quickly; still wait for the digest.
            if (csr_busy) begin
               state_d = WAIT_DIGEST;
            end else if (csr_done) begin
               state_d = WAIT_DIGEST;
               seen_d  = 1'b1;
            end
         end
         WAIT_DIGEST: begin
            if (csr_done) seen_d = 1'b1;
            if (regwrite) begin
               dig_d = digest;
               if (csr_done || seen_q) begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  irq_d   = 1'b1;
                  seen_d  = 1'b0;
                  state_d = IDLE;
               end else begin
                  state_d = WAIT_DONE;
               end
            end
         end
         WAIT_DONE: begin
            if (csr_done) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               irq_d   = 1'b1;
               state_d = IDLE;
            end
         end
         default: ;
      endcase

`ifdef SHA2_HOST_TIMEOUT_EN
      cnt_d = '0;
      if (state_q == WAIT_BUSY || state_q == WAIT_DIGEST || state_q == WAIT_DONE) begin
         cnt_d = cnt_q + 32'd1;
         // Normal completion in the same cycle wins over the watchdog.
         if ((cnt_q >= TIMEOUT_CYCLES - 32'd1) && (state_d != IDLE)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            err_d   = 1'b1;
            tout_d  = 1'b1;
            irq_d   = 1'b1;
            seen_d  = 1'b0;
            dig_d   = dig_q;
         end
      end
`endif
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         msg_q    <= '0;
         size_q   <= '0;
         dig_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         tout_q   <= 1'b0;
         seen_q   <= 1'b0;
         irq_q    <= 1'b0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
`ifdef SHA2_HOST_TIMEOUT_EN
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         msg_q    <= msg_d;
         size_q   <= size_d;
         dig_q    <= dig_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         tout_q   <= tout_d;
         seen_q   <= seen_d;
         irq_q    <= irq_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
`ifdef SHA2_HOST_TIMEOUT_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

   assign plaintext   = msg_q;
   assign messageSize = size_q;
   assign sha2CSR     = (state_q == KICK) ? 3'b100 : 3'b000;
   assign bus_rdata   = rdata_q;
   assign bus_rvalid  = rvalid_q;
   assign irq_done    = irq_q;

endmodule

// File: tb/tb_sha2_host_ctrl.sv
// Testbench for sha2_host_ctrl: host bus driver, wrapper responder and a register-level reference model.
module tb_sha2_host_ctrl;

   logic         clock = 1'b0;
   logic         reset_n = 1'b0;
   logic [4:0]   bus_addr = '0;
   logic [31:0]  bus_wdata = '0;
   logic         bus_we = 1'b0;
   logic         bus_re = 1'b0;
   logic [31:0]  bus_rdata;
   logic         bus_rvalid;
   logic         irq_done;
   logic [447:0] plaintext;
   logic [63:0]  messageSize;
   logic [2:0]   sha2CSR;
   logic [255:0] digest = '0;
   logic [2:0]   sha2CSR_o = '0;
   logic         regwrite = 1'b0;
   logic         csrUpdate = 1'b0;

   always #5 clock = ~clock;

   sha2_host_ctrl #(.TIMEOUT_CYCLES(16)) dut (
      .clock(clock), .reset_n(reset_n),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
      .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid), .irq_done(irq_done),
      .plaintext(plaintext), .messageSize(messageSize), .sha2CSR(sha2CSR),
      .digest(digest), .sha2CSR_o(sha2CSR_o), .regwrite(regwrite), .csrUpdate(csrUpdate)
   );

   localparam logic [255:0] ABC_DIGEST =
      256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

   int checks = 0;
   int failures = 0;
   int kick_cnt = 0;
   int irq_cnt = 0;

   // Reference model: register contents and event counts as a host would expect them.
   logic [31:0] ref_words [14];
   logic [63:0] ref_size;
   logic [31:0] ref_dig [8];
   bit ref_busy, ref_done, ref_err, ref_tout;
   int ref_kick = 0;
   int ref_irq = 0;

   always @(negedge clock) begin
      if (sha2CSR == 3'b100) kick_cnt++;
      if (irq_done) irq_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   function automatic logic [447:0] exp_pt();
      logic [447:0] r;
      for (int i = 0; i < 14; i++) r[447 - 32*i -: 32] = ref_words[i];
      return r;
   endfunction

   function automatic logic [31:0] exp_status();
      return {28'd0, ref_tout, ref_err, ref_done, ref_busy};
   endfunction

   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      if (a <= 5'd13) return ref_words[a];
      if (a == 5'd14) return ref_size[31:0];
      if (a == 5'd15) return ref_size[63:32];
      if (a == 5'd17) return exp_status();
      if (a >= 5'd24) return ref_dig[a - 5'd24];
      return 32'd0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 14; i++) ref_words[i] = '0;
      for (int i = 0; i < 8; i++) ref_dig[i] = '0;
      ref_size = '0;
      ref_busy = 0; ref_done = 0; ref_err = 0; ref_tout = 0;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic host_write(input logic [4:0] a, input logic [31:0] d);
      bus_addr = a; bus_wdata = d; bus_we = 1'b1;
      tick();
      bus_we = 1'b0;
      if (!ref_busy) begin
         if (a <= 5'd13) ref_words[a] = d;
         else if (a == 5'd14) ref_size[31:0] = d;
         else if (a == 5'd15) ref_size[63:32] = d;
         else if (a == 5'd16) begin
            if (d[1]) begin ref_done = 0; ref_err = 0; ref_tout = 0; end
            if (d[0]) begin
               if (ref_size > 64'd447) begin
                  ref_err = 1; ref_irq++;
               end else begin
                  ref_done = 0; ref_err = 0; ref_tout = 0; ref_busy = 1; ref_kick++;
               end
            end
         end
      end
   endtask

   task automatic host_read(input logic [4:0] a, output logic [31:0] d, output logic v);
      bus_addr = a; bus_re = 1'b1;
      tick();
      bus_re = 1'b0;
      d = bus_rdata;
      v = bus_rvalid;
   endtask

   // mode 0: busy, digest, done; mode 1: busy, digest+done together; mode 2: done first, then digest.
   task automatic drive_wrapper(input int mode, input logic [255:0] dg, input int d1, input int d2, input int d3);
      repeat (d1) tick();
      csrUpdate = 1'b1; sha2CSR_o = (mode == 2) ? 3'd1 : 3'd2;
      tick();
      csrUpdate = 1'b0; sha2CSR_o = 3'd0;
      repeat (d2) tick();
      digest = dg; regwrite = 1'b1;
      if (mode == 1) begin csrUpdate = 1'b1; sha2CSR_o = 3'd1; end
      tick();
      regwrite = 1'b0; csrUpdate = 1'b0; sha2CSR_o = 3'd0; digest = ~dg;
      if (mode == 0) begin
         repeat (d3) tick();
         csrUpdate = 1'b1; sha2CSR_o = 3'd1;
         tick();
         csrUpdate = 1'b0; sha2CSR_o = 3'd0;
      end
      for (int k = 0; k < 8; k++) ref_dig[k] = dg[255 - 32*k -: 32];
      ref_busy = 0; ref_done = 1; ref_irq++;
   endtask

   task automatic test_reset();
      logic [31:0] d; logic v;
      reset_n = 1'b0;
      repeat (2) tick();
      reset_n = 1'b1;
      model_reset();
      checks++; if (plaintext !== '0) begin failures++; $display("FAIL reset_plaintext got=%h required=0", plaintext); end
      checks++; if (messageSize !== '0) begin failures++; $display("FAIL reset_size got=%h required=0", messageSize); end
      checks++; if ({sha2CSR, irq_done, bus_rvalid} !== 5'b0) begin failures++;
         $display("FAIL reset_ctrl_outputs got=%b required=0", {sha2CSR, irq_done, bus_rvalid}); end
      host_read(5'h11, d, v);
      checks++; if ({v, d} !== {1'b1, 32'd0}) begin failures++; $display("FAIL reset_status got=%b/%h required=1/0", v, d); end
      host_read(5'h18, d, v);
      checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_digest got=%h required=0", d); end
      tick();
      checks++; if (bus_rvalid !== 1'b0) begin failures++; $display("FAIL rvalid_pulse got=%b required=0", bus_rvalid); end
   endtask

   task automatic test_abc();
      logic [31:0] d; logic v;
      for (int i = 0; i < 13; i++) host_write(5'(i), 32'd0);
      host_write(5'h0D, 32'h00616263);
      host_write(5'h0E, 32'd24);
      host_write(5'h0F, 32'd0);
      host_write(5'h10, 32'd1);
      checks++; if (sha2CSR !== 3'b100) begin failures++; $display("FAIL abc_kick got=%b required=100", sha2CSR); end
      checks++; if ({plaintext, messageSize} !== {exp_pt(), 64'd24}) begin failures++;
         $display("FAIL abc_msg got=%h/%0d required=%h/24", plaintext, messageSize, exp_pt()); end
      tick();
      checks++; if (sha2CSR !== 3'b000) begin failures++; $display("FAIL abc_kick_single got=%b required=000", sha2CSR); end
      host_read(5'h11, d, v);
      checks++; if (d !== exp_status()) begin failures++; $display("FAIL abc_busy_status got=%h required=%h", d, exp_status()); end
      drive_wrapper(0, ABC_DIGEST, 2, 3, 1);
      repeat (2) tick();
      checks++; if (irq_cnt !== ref_irq) begin failures++; $display("FAIL abc_irq got=%0d required=%0d", irq_cnt, ref_irq); end
      for (int k = 0; k < 8; k++) begin
         host_read(5'(24 + k), d, v);
         checks++; if (d !== ABC_DIGEST[255 - 32*k -: 32]) begin failures++;
            $display("FAIL abc_digest[%0d] got=%h required=%h", k, d, ABC_DIGEST[255 - 32*k -: 32]); end
      end
      host_read(5'h11, d, v);
      checks++; if (d !== 32'h2) begin failures++; $display("FAIL abc_status got=%h required=2", d); end
   endtask

   task automatic test_size_err();
      logic [31:0] d; logic v;
      host_write(5'h10, 32'd2);
      host_write(5'h0E, 32'd448);
      host_write(5'h10, 32'd1);
      repeat (3) tick();
      checks++; if (kick_cnt !== ref_kick) begin failures++; $display("FAIL err_no_kick got=%0d required=%0d", kick_cnt, ref_kick); end
      checks++; if (irq_cnt !== ref_irq) begin failures++; $display("FAIL err_irq got=%0d required=%0d", irq_cnt, ref_irq); end
      host_read(5'h11, d, v);
      checks++; if (d !== 32'h4) begin failures++; $display("FAIL err_status got=%h required=4", d); end
      host_write(5'h10, 32'd2);
      host_read(5'h11, d, v);
      checks++; if (d !== exp_status()) begin failures++; $display("FAIL clear_status got=%h required=%h", d, exp_status()); end
   endtask

   task automatic test_busy_ignore();
      logic [31:0] d; logic v;
      host_write(5'h0E, 32'd24);
      host_write(5'h10, 32'd1);
      tick();
      host_write(5'h0D, 32'hFFFF_FFFF);
      host_write(5'h0E, 32'd100);
      host_write(5'h10, 32'd1);
      repeat (2) tick();
      checks++; if ({plaintext, messageSize} !== {exp_pt(), 64'd24}) begin failures++;
         $display("FAIL busy_hold got=%h/%0d required=%h/24", plaintext, messageSize, exp_pt()); end
      checks++; if (kick_cnt !== ref_kick) begin failures++; $display("FAIL busy_one_kick got=%0d required=%0d", kick_cnt, ref_kick); end
      drive_wrapper(0, ABC_DIGEST, 1, 0, 2);
      repeat (2) tick();
      for (int k = 0; k < 8; k++) begin
         host_read(5'(24 + k), d, v);
         checks++; if (d !== ref_dig[k]) begin failures++; $display("FAIL busy_digest[%0d] got=%h required=%h", k, d, ref_dig[k]); end
      end
   endtask

   task automatic test_wrapper_orders(input int mode);
      logic [31:0] d; logic v; logic [255:0] dg;
      for (int k = 0; k < 8; k++) dg[32*k +: 32] = $urandom();
      host_write(5'h0E, 32'd447);
      host_write(5'h0F, 32'd0);
      host_write(5'h10, 32'd1);
      checks++; if (sha2CSR !== 3'b100) begin failures++; $display("FAIL order%0d_kick got=%b required=100", mode, sha2CSR); end
      tick();
      drive_wrapper(mode, dg, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
      repeat (3) tick();
      checks++; if (irq_cnt !== ref_irq) begin failures++; $display("FAIL order%0d_irq got=%0d required=%0d", mode, irq_cnt, ref_irq); end
      host_read(5'h11, d, v);
      checks++; if (d !== 32'h2) begin failures++; $display("FAIL order%0d_status got=%h required=2", mode, d); end
      for (int k = 0; k < 8; k++) begin
         host_read(5'(24 + k), d, v);
         checks++; if (d !== dg[255 - 32*k -: 32]) begin failures++;
            $display("FAIL order%0d_digest[%0d] got=%h required=%h", mode, k, d, dg[255 - 32*k -: 32]); end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d; logic v; int irq_before;
      host_write(5'h0E, 32'd10);
      host_write(5'h10, 32'd1);
      tick();
      csrUpdate = 1'b1; sha2CSR_o = 3'd2;
      tick();
      csrUpdate = 1'b0; sha2CSR_o = 3'd0;
      irq_before = ref_irq;
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      model_reset();
      digest = {8{32'hDEAD_BEEF}}; regwrite = 1'b1; csrUpdate = 1'b1; sha2CSR_o = 3'd1;
      tick();
      regwrite = 1'b0; csrUpdate = 1'b0; sha2CSR_o = 3'd0;
      repeat (2) tick();
      checks++; if ({plaintext, messageSize, sha2CSR, irq_done, bus_rvalid} !== '0) begin failures++;
         $display("FAIL rstmid_outputs got=%h/%h/%b required=0", plaintext, messageSize, {sha2CSR, irq_done, bus_rvalid}); end
      checks++; if (irq_cnt !== irq_before) begin failures++; $display("FAIL rstmid_irq got=%0d required=%0d", irq_cnt, irq_before); end
      host_read(5'h18, d, v);
      checks++; if (d !== 32'd0) begin failures++; $display("FAIL rstmid_digest got=%h required=0", d); end
      host_read(5'h11, d, v);
      checks++; if (d !== 32'd0) begin failures++; $display("FAIL rstmid_status got=%h required=0", d); end
      host_write(5'h10, 32'd1);
      checks++; if (sha2CSR !== 3'b100) begin failures++; $display("FAIL rstmid_idle_start got=%b required=100", sha2CSR); end
      tick();
      drive_wrapper(0, ABC_DIGEST, 0, 0, 0);
      repeat (2) tick();
   endtask

   task automatic test_rw_same_cycle_and_unmapped();
      logic [31:0] d; logic v; logic [31:0] old;
      old = ref_size[31:0];
      bus_addr = 5'h0E; bus_wdata = 32'd321; bus_we = 1'b1; bus_re = 1'b1;
      tick();
      bus_we = 1'b0; bus_re = 1'b0;
      ref_size[31:0] = 32'd321;
      checks++; if (bus_rdata !== old) begin failures++; $display("FAIL rw_pre_write got=%h required=%h", bus_rdata, old); end
      host_read(5'h0E, d, v);
      checks++; if (d !== 32'd321) begin failures++; $display("FAIL rw_post_write got=%h required=321", d); end
      host_write(5'h13, 32'h1234_5678);
      host_write(5'h11, 32'hF);
      for (int a = 16; a < 24; a++) begin
         host_read(5'(a), d, v);
         checks++; if (d !== exp_rd(5'(a))) begin failures++; $display("FAIL unmapped_read[%0h] got=%h required=%h", a, d, exp_rd(5'(a))); end
      end
      checks++; if (plaintext !== exp_pt()) begin failures++; $display("FAIL unmapped_write got=%h required=%h", plaintext, exp_pt()); end
   endtask

   task automatic test_random();
      logic [31:0] d; logic v; logic [255:0] dg; logic [4:0] a;
      for (int it = 0; it < 8; it++) begin
         for (int w = 0; w < 14; w++) host_write(5'(w), $urandom());
         host_write(5'h0E, 32'($urandom_range(0, 520)));
         host_write(5'h0F, (it == 3) ? 32'd1 : 32'd0);
         host_write(5'h10, 32'd1);
         checks++; if (sha2CSR !== (ref_busy ? 3'b100 : 3'b000)) begin failures++;
            $display("FAIL rand%0d_kick got=%b required=%b", it, sha2CSR, ref_busy ? 3'b100 : 3'b000); end
         tick();
         if (ref_busy) begin
            checks++; if ({plaintext, messageSize} !== {exp_pt(), ref_size}) begin failures++;
               $display("FAIL rand%0d_msg got=%h/%0d required=%h/%0d", it, plaintext, messageSize, exp_pt(), ref_size); end
            for (int k = 0; k < 8; k++) dg[32*k +: 32] = $urandom();
            drive_wrapper($urandom_range(0, 2), dg, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
         end
         repeat (2) tick();
         checks++; if (irq_cnt !== ref_irq) begin failures++; $display("FAIL rand%0d_irq got=%0d required=%0d", it, irq_cnt, ref_irq); end
         host_read(5'h11, d, v);
         checks++; if (d !== exp_status()) begin failures++; $display("FAIL rand%0d_status got=%h required=%h", it, d, exp_status()); end
         a = 5'($urandom_range(0, 31));
         host_read(a, d, v);
         checks++; if (d !== exp_rd(a)) begin failures++; $display("FAIL rand%0d_read[%0h] got=%h required=%h", it, a, d, exp_rd(a)); end
         if ($urandom_range(0, 1) == 1) host_write(5'h10, 32'd2);
      end
   endtask

`ifdef SHA2_HOST_TIMEOUT_EN
   task automatic test_timeout();
      logic [31:0] d; logic v;
      host_write(5'h0E, 32'd8);
      host_write(5'h0F, 32'd0);
      host_write(5'h10, 32'd1);
      repeat (20) tick();
      ref_busy = 0; ref_err = 1; ref_tout = 1; ref_irq++;
      host_read(5'h11, d, v);
      checks++; if (d !== 32'hC) begin failures++; $display("FAIL timeout_status got=%h required=C", d); end
      checks++; if (irq_cnt !== ref_irq) begin failures++; $display("FAIL timeout_irq got=%0d required=%0d", irq_cnt, ref_irq); end
      host_write(5'h10, 32'd1);
      tick();
      drive_wrapper(0, ABC_DIGEST, 1, 1, 1);
      repeat (2) tick();
      host_read(5'h11, d, v);
      checks++; if (d !== 32'h2) begin failures++; $display("FAIL timeout_restart got=%h required=2", d); end
   endtask
`endif

   initial begin
      model_reset();
      test_reset();
      test_abc();
      test_size_err();
      test_busy_ignore();
      test_wrapper_orders(1);
      test_wrapper_orders(2);
      test_reset_mid();
      test_rw_same_cycle_and_unmapped();
      test_random();
`ifdef SHA2_HOST_TIMEOUT_EN
      test_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
